// File: rtl/pulse_sched_if.sv
// Configuration, status and strobe bundle between pulse_sched and its controller.
// The master side drives configuration and arm/enable; the slave side is the scheduler.
interface pulse_sched_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             enable;
  logic             arm;
  logic [CNT_W-1:0] period;
  logic [15:0]      burst_len;
  logic [15:0]      td_min;
  logic [15:0]      td_max;
  logic [15:0]      td_step;
  logic [11:0]      width_in;
  logic             start_out;
  logic [15:0]      time_double;
  logic [11:0]      width;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    output enable, arm, period, burst_len, td_min, td_max, td_step, width_in,
    input  start_out, time_double, width, busy, done, pulse_cnt
  );

  modport slave (
    input  enable, arm, period, burst_len, td_min, td_max, td_step, width_in,
    output start_out, time_double, width, busy, done, pulse_cnt
  );
endinterface

// File: rtl/pulse_sched.sv
// Burst scheduler for the double-pulse generator: fixed-period start strobes with a swept
// time_double. Define PULSE_SCHED_LFSR_EN to draw time_double from a 16-bit LFSR instead.
module pulse_sched #(
  parameter int unsigned START_HOLD = 4,
  parameter int unsigned CNT_W      = 32
) (
  input logic          clk,
  input logic          rstn,
  pulse_sched_if.slave bus
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StFire = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(START_HOLD - 1);
  localparam logic [CNT_W-1:0] MinPeriod = CNT_W'(2 * START_HOLD);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] tick_q;
  logic [CNT_W-1:0] peff_q;
  logic [15:0]      burst_q;
  logic [15:0]      tmin_q;
  logic [15:0]      tstep_q;
  logic [15:0]      td_q;
  logic [15:0]      td_next;
  logic [11:0]      width_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_q, busy_q, done_q;
  logic             expire, last_strobe;

  assign expire      = (tick_q == peff_q - CntOne);
  assign last_strobe = (burst_q != 16'd0) && (cnt_q == CNT_W'(burst_q));

  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (bus.arm) state_d = StLoad;
        StLoad:  state_d = StFire;
        StFire:  if (tick_q == HoldLast) state_d = StWait;
        StWait:  if (expire) state_d = last_strobe ? StDone : StFire;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef PULSE_SCHED_LFSR_EN
  logic [15:0] lfsr_q;

  // Advances once per strobe, on the same edge that counts it; only reset reseeds it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= 16'hACE1;
    end else if (bus.enable && state_q == StFire && tick_q == '0) begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign td_next = tmin_q + (lfsr_q & tstep_q);
`else
  logic [15:0] tmax_q;
  logic [16:0] sum;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmax_q <= '0;
    end else if (bus.enable && state_q == StLoad) begin
      tmax_q <= bus.td_max;
    end
  end

  // A carry into bit 16 always exceeds td_max, so it wraps like any other overshoot.
  always_comb begin
    sum = {1'b0, td_q} + {1'b0, tstep_q};
    if (tmin_q > tmax_q || sum > {1'b0, tmax_q}) begin
      td_next = tmin_q;
    end else begin
      td_next = sum[15:0];
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      tick_q  <= '0;
      peff_q  <= '0;
      burst_q <= '0;
      tmin_q  <= '0;
      tstep_q <= '0;
      td_q    <= '0;
      width_q <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Flags follow the state one cycle later; enable low squashes them at once.
      start_q <= bus.enable && (state_q == StFire);
      busy_q  <= bus.enable && (state_q != StIdle);
      done_q  <= bus.enable && (state_q == StDone);
      if (bus.enable) begin
        case (state_q)
          StLoad: begin
            peff_q  <= (bus.period < MinPeriod) ? MinPeriod : bus.period;
            burst_q <= bus.burst_len;
            tmin_q  <= bus.td_min;
            tstep_q <= bus.td_step;
            td_q    <= bus.td_min;
            width_q <= bus.width_in;
            cnt_q   <= '0;
            tick_q  <= '0;
          end
          StFire: begin
            tick_q <= tick_q + CntOne;
            if (tick_q == '0) cnt_q <= cnt_q + CntOne;
          end
          StWait: begin
            if (expire) begin
              tick_q <= '0;
              if (!last_strobe) td_q <= td_next;
            end else begin
              tick_q <= tick_q + CntOne;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.start_out   = start_q;
  assign bus.time_double = td_q;
  assign bus.width       = width_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pulse_cnt   = cnt_q;

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched: a table of finite bursts plus hand-written corner sequences.
module tb_pulse_sched;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned START_HOLD = 4;
  localparam int          NVEC       = 7;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  pulse_sched_if #(.CNT_W(CNT_W)) bus ();

  pulse_sched #(
    .START_HOLD(START_HOLD),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      period;
    logic [15:0]      burst;
    logic [15:0]      tmin;
    logic [15:0]      tmax;
    logic [15:0]      tstep;
    logic [11:0]      w;
    logic [31:0]      spacing;
    logic [3:0][15:0] td;
  } vec_t;

  vec_t        vecs [NVEC];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] lfsr_m = 16'hACE1;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic vec_t mk(input logic [31:0] period, input logic [15:0] burst,
                              input logic [15:0] tmin, input logic [15:0] tmax,
                              input logic [15:0] tstep, input logic [11:0] w,
                              input logic [31:0] spacing, input logic [15:0] t0,
                              input logic [15:0] t1, input logic [15:0] t2,
                              input logic [15:0] t3);
    vec_t v;
    v.period = period; v.burst = burst; v.tmin = tmin; v.tmax = tmax; v.tstep = tstep;
    v.w = w; v.spacing = spacing;
    v.td[0] = t0; v.td[1] = t1; v.td[2] = t2; v.td[3] = t3;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic set_cfg(input logic [31:0] period, input logic [15:0] burst,
                         input logic [15:0] tmin, input logic [15:0] tmax,
                         input logic [15:0] tstep, input logic [11:0] w);
    bus.period = period; bus.burst_len = burst; bus.td_min = tmin;
    bus.td_max = tmax;   bus.td_step = tstep;   bus.width_in = w;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 32'(bus.start_out), 0);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_done"},  32'(bus.done), 0);
    check({tag, "_td"},    32'(bus.time_double), 0);
    check({tag, "_width"}, 32'(bus.width), 0);
    check({tag, "_cnt"},   bus.pulse_cnt, 0);
  endtask

  // One finite burst; t counts negedges after arm is first presented.
  task automatic run_vec(input vec_t v);
    int          t, nrise, last_rise, hi, tdone;
    logic        prev_s;
    logic [15:0] prev_td, exp_td;
    bit          fin;
    @(negedge clk);
    set_cfg(v.period, v.burst, v.tmin, v.tmax, v.tstep, v.w);
    bus.arm = 1'b1;
    t = 0; nrise = 0; last_rise = 0; hi = 0; tdone = -1;
    prev_s = 1'b0; prev_td = '0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        bus.arm = 1'b0;
        check("busy_in_load", 32'(bus.busy), 0);
      end
      if (t == 2) begin
        check("busy_rise", 32'(bus.busy), 1);
        set_cfg(32'd5, 16'd9, 16'h1234, 16'h0001, 16'h0777, 12'hFFF);
      end
      if (t == 6) bus.arm = 1'b1;
      if (t == 7) bus.arm = 1'b0;
      if (bus.start_out && !prev_s) begin
        nrise++;
        if (nrise == 1) check("first_rise", t, 3);
        else            check("spacing", t - last_rise, v.spacing);
`ifdef PULSE_SCHED_LFSR_EN
        exp_td = (nrise == 1) ? v.tmin : v.tmin + (lfsr_m & v.tstep);
        lfsr_m = lfsr_adv(lfsr_m);
        if ({1'b0, v.tmin} + {1'b0, v.tstep} <= 17'h0FFFF)
          check("td_range", 32'(bus.time_double >= v.tmin &&
                                bus.time_double <= v.tmin + v.tstep), 1);
`else
        exp_td = (nrise <= 4) ? v.td[nrise-1] : 16'hDEAD;
`endif
        check("td", 32'(bus.time_double), 32'(exp_td));
        check("td_setup", 32'(prev_td), 32'(exp_td));
        check("width", 32'(bus.width), 32'(v.w));
        check("cnt_at_rise", bus.pulse_cnt, nrise);
        last_rise = t;
        hi = 1;
      end else if (bus.start_out) begin
        hi++;
      end
      if (!bus.start_out && prev_s) check("hold", hi, START_HOLD);
      if (bus.done) begin
        check("done_time", t - last_rise, v.spacing);
        check("final_cnt", bus.pulse_cnt, 32'(v.burst));
        tdone = t;
      end
      if (tdone >= 0 && t == tdone + 1) begin
        check("busy_fall", 32'(bus.busy), 0);
        check("done_one_cycle", 32'(bus.done), 0);
        fin = 1'b1;
      end
      if (t > 3000) begin
        checks++; errors++;
        $display("FAIL burst_timeout: no done after %0d cycles", t);
        fin = 1'b1;
      end
      prev_s  = bus.start_out;
      prev_td = bus.time_double;
    end
    check("strobes", nrise, 32'(v.burst));
    repeat (4) @(negedge clk);
    check("no_restart_busy", 32'(bus.busy), 0);
    check("no_restart_start", 32'(bus.start_out), 0);
  endtask

  initial begin
    int          t, nrise, last_rise, hi, ndone, r1, r2;
    logic        prev_s;
    bit          fin;

    vecs[0] = mk(100, 3, 10, 30, 10, 12'h123, 100, 10, 20, 30, 0);
    vecs[1] = mk(20, 4, 10, 25, 10, 12'h0AA, 20, 10, 20, 10, 20);
    vecs[2] = mk(3, 3, 5, 100, 7, 12'h001, 8, 5, 12, 19, 0);
    vecs[3] = mk(12, 3, 50, 40, 5, 12'h7FF, 12, 50, 50, 50, 0);
    vecs[4] = mk(9, 2, 7, 100, 0, 12'h555, 9, 7, 7, 0, 0);
    vecs[5] = mk(8, 3, 16'hFFE0, 16'hFFFF, 16'h0010, 12'hFED, 8, 16'hFFE0, 16'hFFF0,
                 16'hFFE0, 0);
    vecs[6] = mk(10, 4, 100, 0, 16'h00FF, 12'h321, 10, 100, 100, 100, 100);

    bus.enable = 1'b1;
    bus.arm    = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Continuous burst, enable dropped during the 7th strobe.
    @(negedge clk);
    set_cfg(50, 0, 0, 1000, 1, 12'h00F);
    bus.arm = 1'b1;
    t = 0; nrise = 0; last_rise = 0; hi = 0; ndone = 0; prev_s = 1'b0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      t++;
      if (t == 1) bus.arm = 1'b0;
      if (bus.done) ndone++;
      if (bus.start_out && !prev_s) begin
        nrise++;
        if (nrise > 1) check("cont_spacing", t - last_rise, 50);
`ifdef PULSE_SCHED_LFSR_EN
        lfsr_m = lfsr_adv(lfsr_m);
`else
        check("cont_td", 32'(bus.time_double), nrise - 1);
`endif
        last_rise = t;
        hi = 1;
      end else if (bus.start_out) begin
        hi++;
      end
      if (nrise == 7 && hi == 2) begin
        bus.enable = 1'b0;
        @(negedge clk);
        check("abort_start", 32'(bus.start_out), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_cnt", bus.pulse_cnt, 7);
        fin = 1'b1;
      end
      if (t > 1000) begin
        checks++; errors++;
        $display("FAIL cont_timeout: only %0d strobes by cycle %0d", nrise, t);
        fin = 1'b1;
      end
      prev_s = bus.start_out;
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_cnt_held", bus.pulse_cnt, 7);
    check("abort_idle", 32'(bus.busy), 0);
    bus.enable = 1'b1;

    // arm held high through DONE restarts immediately.
    @(negedge clk);
    set_cfg(8, 1, 33, 40, 1, 12'h011);
    bus.arm = 1'b1;
    r1 = -1; r2 = -1; prev_s = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 13) bus.arm = 1'b0;
      if (k == 12) check("rearm_gap_busy", 32'(bus.busy), 0);
      if (bus.start_out && !prev_s) begin
        check("rearm_td", 32'(bus.time_double), 33);
`ifdef PULSE_SCHED_LFSR_EN
        lfsr_m = lfsr_adv(lfsr_m);
`endif
        if (r1 < 0) r1 = k;
        else if (r2 < 0) r2 = k;
      end
      prev_s = bus.start_out;
    end
    check("rearm_rise1", r1, 3);
    check("rearm_rise2", r2, 14);
    check("rearm_end_busy", 32'(bus.busy), 0);

    // arm rising together with enable falling stays idle.
    @(negedge clk);
    bus.enable = 1'b0;
    bus.arm    = 1'b1;
    repeat (3) @(negedge clk);
    check("en_wins_busy", 32'(bus.busy), 0);
    check("en_wins_start", 32'(bus.start_out), 0);
    bus.arm    = 1'b0;
    bus.enable = 1'b1;

    // Asynchronous reset mid-FIRE clears every output without a clock edge.
    @(negedge clk);
    set_cfg(20, 3, 5, 50, 5, 12'hABC);
    bus.arm = 1'b1;
    nrise = 0; hi = 0; prev_s = 1'b0; fin = 1'b0; t = 0;
    while (!fin) begin
      @(negedge clk);
      t++;
      if (t == 1) bus.arm = 1'b0;
      if (bus.start_out && !prev_s) begin nrise++; hi = 1; end
      else if (bus.start_out) hi++;
      if (nrise == 2 && hi == 2) begin
        #2 rstn = 1'b0;
        #1;
        check_all_zero("async_reset");
        lfsr_m = 16'hACE1;
        fin = 1'b1;
      end
      if (t > 200) begin
        checks++; errors++;
        $display("FAIL reset_seq_timeout: %0d strobes seen", nrise);
        fin = 1'b1;
      end
      prev_s = bus.start_out;
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
